// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared constants for the video timing generator: the coordinate width and
//   the standard 1280x720@60 and 640x480@60 timing sets, plus a small window
//   decode helper used for the sync pulses.
package video_timing_pkg;

  localparam int unsigned COORD_W = 16;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } timing_t;

  // 1280x720@60, 74.25 MHz pixel clock, 1650 x 750 total
  localparam timing_t TIMING_720P60 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
  };

  // 640x480@60, 25.175 MHz pixel clock, 800 x 525 total
  localparam timing_t TIMING_480P60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  // True when lo <= v < hi
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// video_axis_counter
//   Wrapping counter 0..TOTAL-1 for one raster axis.
//   Ports:
//     clk     - clock
//     rst_n   - asynchronous active-low reset (count -> 0)
//     adv     - advance the count on this edge
//     cnt     - registered count
//     cnt_nxt - value cnt takes on the next edge (lets the parent register
//               decodes that line up with the new count)
//     tc      - terminal count, cnt == TOTAL-1
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned TOTAL = 1650
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
  output logic [COORD_W-1:0] cnt,
  output logic [COORD_W-1:0] cnt_nxt,
  output logic               tc
);

  localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

  assign tc = (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (adv) begin
      cnt_nxt = tc ? '0 : cnt + COORD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator: column/line counters with registered sync,
//   data-enable and start-of-line/frame strobes, all aligned to the counters.
//   Ports:
//     i_clk          - pixel-domain clock
//     i_rst_n        - asynchronous active-low reset
//     i_pix_en       - pixel advance enable; all outputs hold while low
//     o_x, o_y       - current column / line
//     o_h_sync       - horizontal sync (asserted level = SYNC_POL)
//     o_v_sync       - vertical sync (asserted level = SYNC_POL)
//     o_de           - visible-area data enable
//     o_line_start   - high while o_x == 0
//     o_frame_start  - high while (o_x, o_y) == (0, 0)
//     o_frame_count  - frames started since reset, wraps mod 2^16
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = TIMING_720P60.h_active,
  parameter int unsigned H_FP     = TIMING_720P60.h_fp,
  parameter int unsigned H_SYNC   = TIMING_720P60.h_sync,
  parameter int unsigned H_BP     = TIMING_720P60.h_bp,
  parameter int unsigned V_ACTIVE = TIMING_720P60.v_active,
  parameter int unsigned V_FP     = TIMING_720P60.v_fp,
  parameter int unsigned V_SYNC   = TIMING_720P60.v_sync,
  parameter int unsigned V_BP     = TIMING_720P60.v_bp,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_en,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_h_sync,
  output logic               o_v_sync,
  output logic               o_de,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic [COORD_W-1:0] o_frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_ACT_W = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HS_LO   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_HI   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_ACT_W = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VS_LO   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_HI   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  // After reset the outputs sit in an idle state (o_de and strobes low).
  // The first enabled edge only enters (0,0) without moving the counters;
  // real advancing starts from the second enabled edge.
  logic               started;
  logic               h_adv;
  logic               v_adv;
  logic               h_tc;
  logic               v_tc;
  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;

  assign h_adv = i_pix_en & started;
  assign v_adv = h_adv & h_tc;

  video_axis_counter #(
    .TOTAL (H_TOTAL)
  ) u_h_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .adv     (h_adv),
    .cnt     (o_x),
    .cnt_nxt (x_nxt),
    .tc      (h_tc)
  );

  video_axis_counter #(
    .TOTAL (V_TOTAL)
  ) u_v_cnt (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .adv     (v_adv),
    .cnt     (o_y),
    .cnt_nxt (y_nxt),
    .tc      (v_tc)
  );

  // Decodes are taken from the next coordinates so the registered strobes
  // land in the same cycle as the counters they describe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      started       <= 1'b0;
      o_de          <= 1'b0;
      o_h_sync      <= ~SYNC_POL;
      o_v_sync      <= ~SYNC_POL;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_count <= '0;
    end else if (i_pix_en) begin
      started       <= 1'b1;
      o_de          <= (x_nxt < H_ACT_W) && (y_nxt < V_ACT_W);
      o_h_sync      <= in_window(x_nxt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      o_v_sync      <= in_window(y_nxt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
      o_line_start  <= (x_nxt == '0);
      o_frame_start <= (x_nxt == '0) && (y_nxt == '0);
      // Only a real wrap into (0,0) counts; the initial entry does not.
      if (v_adv && v_tc) begin
        o_frame_count <= o_frame_count + COORD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance: H 8/2/2/2, V 4/1/1/1, active-high syncs
  logic        rst_n_s, en_s;
  logic [15:0] x_s, y_s, fc_s;
  logic        hs_s, vs_s, de_s, ls_s, fs_s;
  // wide instance: default horizontal timing, small vertical, active-low syncs
  logic        rst_n_w, en_w;
  logic [15:0] x_w, y_w, fc_w;
  logic        hs_w, vs_w, de_w, ls_w, fs_w;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) u_small (
    .i_clk(clk), .i_rst_n(rst_n_s), .i_pix_en(en_s),
    .o_x(x_s), .o_y(y_s), .o_h_sync(hs_s), .o_v_sync(vs_s), .o_de(de_s),
    .o_line_start(ls_s), .o_frame_start(fs_s), .o_frame_count(fc_s)
  );

  video_timing_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) u_wide (
    .i_clk(clk), .i_rst_n(rst_n_w), .i_pix_en(en_w),
    .o_x(x_w), .o_y(y_w), .o_h_sync(hs_w), .o_v_sync(vs_w), .o_de(de_w),
    .o_line_start(ls_w), .o_frame_start(fs_w), .o_frame_count(fc_w)
  );

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } cfg_t;

  typedef struct {
    int x, y, fc;
    bit de, hs, vs, ls, fs;
  } exp_t;

  typedef struct {
    bit en;
    int x, y;
    bit de, hs, vs, ls, fs;
    int fc;
  } vec_t;

  int    n_vec = 0;
  int    n_bad = 0;
  longint n_s = 0;  // enabled edges since reset release, small instance
  longint n_w = 0;
  cfg_t  cfg_s, cfg_w;

  // Reference: output state after n enabled edges since reset release.
  function automatic exp_t model(longint n, cfg_t c);
    exp_t e;
    longint k, ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    e.x = 0; e.y = 0; e.fc = 0;
    e.de = 0; e.ls = 0; e.fs = 0;
    e.hs = !c.pol; e.vs = !c.pol;
    if (n == 0) return e;
    k    = n - 1;
    e.x  = int'(k % ht);
    e.y  = int'((k / ht) % vt);
    e.fc = int'((k / (ht * vt)) % 65536);
    e.de = (e.x < c.ha) && (e.y < c.va);
    e.hs = (e.x >= c.ha + c.hf && e.x < c.ha + c.hf + c.hs) ? c.pol : !c.pol;
    e.vs = (e.y >= c.va + c.vf && e.y < c.va + c.vf + c.vs) ? c.pol : !c.pol;
    e.ls = (e.x == 0);
    e.fs = (e.x == 0) && (e.y == 0);
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_s(input string tag);
    exp_t e;
    e = model(n_s, cfg_s);
    chk({tag, ".x"}, x_s, e.x);
    chk({tag, ".y"}, y_s, e.y);
    chk({tag, ".de"}, de_s, e.de);
    chk({tag, ".hs"}, hs_s, e.hs);
    chk({tag, ".vs"}, vs_s, e.vs);
    chk({tag, ".ls"}, ls_s, e.ls);
    chk({tag, ".fs"}, fs_s, e.fs);
    chk({tag, ".fc"}, fc_s, e.fc);
  endtask

  task automatic cmp_w(input string tag);
    exp_t e;
    e = model(n_w, cfg_w);
    chk({tag, ".x"}, x_w, e.x);
    chk({tag, ".y"}, y_w, e.y);
    chk({tag, ".de"}, de_w, e.de);
    chk({tag, ".hs"}, hs_w, e.hs);
    chk({tag, ".vs"}, vs_w, e.vs);
    chk({tag, ".ls"}, ls_w, e.ls);
    chk({tag, ".fs"}, fs_w, e.fs);
    chk({tag, ".fc"}, fc_w, e.fc);
  endtask

  // Called at posedge+1; drives enable for the next edge and returns at posedge+1.
  task automatic tick_s(input bit en);
    en_s = en;
    @(posedge clk);
    #1;
    if (en) n_s++;
  endtask

  task automatic tick_w(input bit en);
    en_w = en;
    @(posedge clk);
    #1;
    if (en) n_w++;
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge.
  task automatic reset_s(input string tag);
    en_s = 1'b0;
    #2 rst_n_s = 1'b0;
    #1;
    n_s = 0;
    cmp_s({tag, "_async"});
    @(negedge clk);
    rst_n_s = 1'b1;
    @(posedge clk);
    #1;
    cmp_s({tag, "_idle"});
  endtask

  vec_t tbl[6];
  int   fs_cyc[$];
  int   fs_cnt[$];

  initial begin
    cfg_s = '{ha:8, hf:2, hs:2, hb:2, va:4, vf:1, vs:1, vb:1, pol:1'b1};
    cfg_w = '{ha:1280, hf:110, hs:40, hb:220, va:4, vf:1, vs:1, vb:1, pol:1'b0};

    //            en  x  y  de hs vs ls fs fc
    tbl[0] = '{1'b0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1'b1, 0, 0, 1, 0, 0, 1, 1, 0};
    tbl[2] = '{1'b1, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{1'b0, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[4] = '{1'b0, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[5] = '{1'b1, 2, 0, 1, 0, 0, 0, 0, 0};

    // Reset held with enable high: outputs stay at reset values.
    rst_n_s = 1'b0; en_s = 1'b1;
    rst_n_w = 1'b0; en_w = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_s = 0;
    cmp_s("reset_s");
    cmp_w("reset_w");
    en_s = 1'b0;
    @(negedge clk);
    rst_n_s = 1'b1;
    @(posedge clk);
    #1;

    // Hand-written start-up vectors
    for (int i = 0; i < 6; i++) begin
      tick_s(tbl[i].en);
      chk($sformatf("tbl%0d.x", i), x_s, tbl[i].x);
      chk($sformatf("tbl%0d.y", i), y_s, tbl[i].y);
      chk($sformatf("tbl%0d.de", i), de_s, tbl[i].de);
      chk($sformatf("tbl%0d.hs", i), hs_s, tbl[i].hs);
      chk($sformatf("tbl%0d.vs", i), vs_s, tbl[i].vs);
      chk($sformatf("tbl%0d.ls", i), ls_s, tbl[i].ls);
      chk($sformatf("tbl%0d.fs", i), fs_s, tbl[i].fs);
      chk($sformatf("tbl%0d.fc", i), fc_s, tbl[i].fc);
    end

    // Random enable against the reference model (several frames)
    for (int i = 0; i < 800; i++) begin
      tick_s($urandom_range(0, 3) != 0);
      cmp_s("rand");
    end

    // Freeze at (3,2) for 5 disabled cycles, then advance to (4,2)
    reset_s("rst_freeze");
    repeat (32) tick_s(1'b1);
    chk("freeze_pre.x", x_s, 3);
    chk("freeze_pre.y", y_s, 2);
    for (int i = 0; i < 5; i++) begin
      tick_s(1'b0);
      chk("freeze.x", x_s, 3);
      chk("freeze.y", y_s, 2);
      chk("freeze.de", de_s, 1);
      cmp_s("freeze");
    end
    tick_s(1'b1);
    chk("unfreeze.x", x_s, 4);
    chk("unfreeze.y", y_s, 2);

    // Three full frames: frame_start cycles and counts
    reset_s("rst_frames");
    for (int c = 1; c <= 295; c++) begin
      tick_s(1'b1);
      cmp_s("frames");
      if (fs_s) begin
        fs_cyc.push_back(c);
        fs_cnt.push_back(int'(fc_s));
      end
    end
    chk("fs_pulses", fs_cyc.size(), 4);
    if (fs_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("fs_cycle%0d", i), fs_cyc[i], 1 + 98 * i);
        chk($sformatf("fs_count%0d", i), fs_cnt[i], i);
      end
    end

    // Mid-frame asynchronous reset at (9,3), then restart from (0,0)
    reset_s("rst_mid0");
    repeat (52) tick_s(1'b1);
    chk("mid.x", x_s, 9);
    chk("mid.y", y_s, 3);
    reset_s("rst_mid");
    tick_s(1'b1);
    chk("restart.x", x_s, 0);
    chk("restart.y", y_s, 0);
    chk("restart.fs", fs_s, 1);
    chk("restart.fc", fc_s, 0);
    repeat (20) begin
      tick_s(1'b1);
      cmp_s("restart");
    end

    // 4:1 enable cadence over one frame
    reset_s("rst_4to1");
    for (int i = 0; i < 98 * 4 + 4; i++) begin
      tick_s((i % 4) == 0);
      cmp_s("cad4");
    end

    // Wide instance: default horizontal timing, active-low syncs, one frame
    @(negedge clk);
    rst_n_w = 1'b1;
    @(posedge clk);
    #1;
    n_w = 0;
    cmp_w("wide_idle");
    for (int c = 1; c <= 1650 * 7 + 2; c++) begin
      tick_w(1'b1);
      cmp_w("wide");
    end
    chk("wide_period.fc", fc_w, 1);
    chk("wide_period.x", x_w, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter H_ACTIVE, 1280, visible pixels per line.
REQ-003 Parameter H_FP, 110, horizontal front porch in pixels.
REQ-004 Parameter H_SYNC, 40, horizontal sync width in pixels.
REQ-005 Parameter H_BP, 220, horizontal back porch in pixels.
REQ-006 Parameter V_ACTIVE, 720, visible lines per frame.
REQ-007 Parameter V_FP, 5, vertical front porch in lines.
REQ-008 Parameter V_SYNC, 5, vertical sync width in lines.
REQ-009 Parameter V_BP, 20, vertical back porch in lines.
REQ-010 Parameter SYNC_POL, 1'b1, asserted level of both syncs (1 = active-high).
REQ-011 Port i_clk, input, 1, pixel-domain clock.
REQ-012 Port i_rst_n, input, 1, asynchronous active-low reset.
REQ-013 Port i_pix_en, input, 1, pixel advance enable.
REQ-014 Port o_x, output, 16, current column (0..H_TOTAL-1).
REQ-015 Port o_y, output, 16, current line (0..V_TOTAL-1).
REQ-016 Port o_h_sync, output, 1, horizontal sync.
REQ-017 Port o_v_sync, output, 1, vertical sync.
REQ-018 Port o_de, output, 1, high when o_x < H_ACTIVE and o_y < V_ACTIVE.
REQ-019 Port o_line_start, output, 1, high when o_x == 0.
REQ-020 Port o_frame_start, output, 1, high when o_x == 0 and o_y == 0.
REQ-021 Port o_frame_count, output, 16, frames started since reset.

Function
REQ-022 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP; 720p defaults give 1650 x 750.
REQ-023 All outputs SHALL be flop outputs, mutually consistent in the same cycle, with no combinational path from i_pix_en.
REQ-024 On each rising i_clk with i_pix_en=1, o_x SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and o_y SHALL increment; o_y SHALL wrap from V_TOTAL-1 to 0.
REQ-025 With i_pix_en=0, every output SHALL hold its value, including the o_line_start and o_frame_start pulses.
REQ-026 o_h_sync SHALL equal SYNC_POL for H_ACTIVE+H_FP <= o_x < H_ACTIVE+H_FP+H_SYNC, and ~SYNC_POL otherwise.
REQ-027 o_v_sync SHALL equal SYNC_POL for V_ACTIVE+V_FP <= o_y < V_ACTIVE+V_FP+V_SYNC, over whole lines (x = 0..H_TOTAL-1), and ~SYNC_POL otherwise.
REQ-028 o_x/o_y SHALL keep counting through blanking; downstream sprites gate on o_de.
REQ-029 o_frame_count SHALL increment, wrapping modulo 2^16, on every advance into (0,0) after the first one.
REQ-030 Counter width SHALL be 16 bits; parameters with H_TOTAL or V_TOTAL > 65535 are unsupported.

Reset
REQ-031 While i_rst_n=0: o_x=0, o_y=0, o_de=0, o_line_start=0, o_frame_start=0, o_frame_count=0, and both syncs = ~SYNC_POL.
REQ-032 On the first i_pix_en-qualified edge after release, outputs SHALL show (0,0) with o_de=1, o_line_start=1, o_frame_start=1, and o_frame_count=0.
REQ-033 Reset asserted mid-frame SHALL force the REQ-031 values immediately, without waiting for a clock; no partial frame SHALL resume.

Structure
REQ-034 Package video_timing_pkg SHALL hold the 1280x720@60 and 640x480@60 timing constant sets and the 16-bit coordinate width.
REQ-035 One sub-module, video_axis_counter (wrapping counter with terminal-count output), SHALL be instantiated twice, for horizontal and vertical.

Verification
REQ-036 Small config (H 8/2/2/2, V 4/1/1/1, i.e. 14 x 7), i_pix_en=1 -> o_x wraps 13->0; o_de high for x 0..7, y 0..3; o_h_sync high for x 10..11; o_v_sync high for all of y=5.
REQ-037 Small config, i_pix_en held 0 for 5 cycles at (3,2) -> outputs frozen at (3,2), o_de=1; advances to (4,2) on the next enabled edge.
REQ-038 Reset released, then 3 full frames (294 cycles) -> o_frame_start pulses at cycles 1, 99, 197 and 295; o_frame_count reads 0, 1, 2, 3.
REQ-039 Reset asserted at (9,3) between edges -> outputs at REQ-031 values before the next edge; after release the sequence restarts at (0,0).
REQ-040 Defaults with SYNC_POL=0 -> o_h_sync low exactly for x 1390..1429; o_v_sync low exactly for y 725..729; frame period 1,237,500 enabled cycles.
REQ-041 Enable pattern 1-0-0-0 (4:1), one frame -> outputs identical to the 1:1 run once each output is sampled on its enabled cycles.
